// File: rtl/game_state_controller_pkg.sv
// Shared types and constants for the game sequencer: state encoding, BCD digit
// type, default point values and a one-digit BCD add helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    DYING      = 3'd2,
    LEVEL_DONE = 3'd3,
    GAME_OVER  = 3'd4
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] FRUIT_POINTS_DEF = 16'h0010;
  localparam logic [15:0] GOAL_POINTS_DEF  = 16'h0100;
  localparam logic [15:0] SCORE_MAX        = 16'h9999;
  localparam logic [2:0]  LIVES_MAX        = 3'd7;
  localparam int unsigned TIMER_W          = 16;

  // Returns {carry_out, digit}; inputs are assumed to be valid BCD digits.
  function automatic logic [4:0] bcd_digit_add(input bcd_digit_t a, input bcd_digit_t b,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) begin
      bcd_digit_add = {1'b1, s[3:0] + 4'd6};
    end else begin
      bcd_digit_add = {1'b0, s[3:0]};
    end
  endfunction

endpackage

// File: rtl/game_state_controller_bcd_score_adder.sv
// Combinational 4-digit packed-BCD adder that saturates at 9999 and flags when
// the thousands digit of the result moves past that of the augend.
module bcd_score_adder
  import game_pkg::*;
#(
  parameter bit BONUS_EN = 1'b0
) (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic        o_thou_carry
);

  logic [15:0] w_raw;
  logic [4:0]  w_dsum;
  logic        w_carry;

  // Ripple the per-digit carry from the units digit up to the thousands digit.
  always_comb begin
    w_raw   = 16'h0000;
    w_dsum  = 5'd0;
    w_carry = 1'b0;
    for (int d = 0; d < 4; d++) begin
      w_dsum          = bcd_digit_add(i_a[4*d +: 4], i_b[4*d +: 4], w_carry);
      w_raw[4*d +: 4] = w_dsum[3:0];
      w_carry         = w_dsum[4];
    end
  end

  assign o_sum        = w_carry ? SCORE_MAX : w_raw;
  assign o_thou_carry = BONUS_EN && (o_sum[15:12] > i_a[15:12]);

endmodule

// File: rtl/game_state_controller.sv
// Game phase sequencer: lives, BCD score, level, freeze and respawn control.
// Optional bonus life on each new thousands digit: define GAME_BONUS_LIFE_EN.
module game_state_controller
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = 3,
  parameter logic [15:0] FRUIT_POINTS = FRUIT_POINTS_DEF,
  parameter logic [15:0] GOAL_POINTS  = GOAL_POINTS_DEF,
  parameter int unsigned DIE_FRAMES   = 60,
  parameter int unsigned WIN_FRAMES   = 90,
  parameter int unsigned MAX_LEVEL    = 9
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic        fruitHit,
  input  logic        barrelHit,
  input  logic        goalHit,
  output game_state_t gameState,
  output logic        freeze,
  output logic        respawnPulse,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [3:0]  level
);

`ifdef GAME_BONUS_LIFE_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  localparam logic [2:0]         LIVES_INIT_V = LIVES_INIT[2:0];
  localparam logic [TIMER_W-1:0] DIE_V        = DIE_FRAMES[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] WIN_V        = WIN_FRAMES[TIMER_W-1:0];
  localparam logic [3:0]         MAX_LEVEL_V  = MAX_LEVEL[3:0];

  game_state_t        r_state, w_next_state;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic [2:0]         r_lives, w_lives_nxt;
  logic [15:0]        r_score, w_score_nxt;
  logic [3:0]         r_level, w_level_nxt;
  logic               r_respawn, w_respawn_nxt;
  logic               r_freeze;

  logic [15:0] w_fruit_add, w_goal_add, w_score_f, w_score_fg;
  logic        w_thou_f, w_thou_g, w_bonus, w_timer_exp, w_goal_taken;

  // A barrel hit in the same clock cancels the goal, including its points.
  assign w_goal_taken = goalHit && !barrelHit;
  assign w_fruit_add  = fruitHit ? FRUIT_POINTS : 16'h0000;
  assign w_goal_add   = w_goal_taken ? GOAL_POINTS : 16'h0000;
  assign w_bonus      = w_thou_f || w_thou_g;
  assign w_timer_exp  = startOfFrame && (r_timer == {{(TIMER_W-1){1'b0}}, 1'b1});

  bcd_score_adder #(.BONUS_EN(BONUS_EN)) u_add_fruit (
    .i_a          (r_score),
    .i_b          (w_fruit_add),
    .o_sum        (w_score_f),
    .o_thou_carry (w_thou_f)
  );

  bcd_score_adder #(.BONUS_EN(BONUS_EN)) u_add_goal (
    .i_a          (w_score_f),
    .i_b          (w_goal_add),
    .o_sum        (w_score_fg),
    .o_thou_carry (w_thou_g)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, GAME_OVER: w_next_state = startKey ? PLAY : r_state;
      PLAY: begin
        if (barrelHit) begin
          w_next_state = DYING;
        end else if (goalHit) begin
          w_next_state = LEVEL_DONE;
        end else begin
          w_next_state = PLAY;
        end
      end
      DYING: begin
        if (w_timer_exp) begin
          w_next_state = (r_lives == 3'd0) ? GAME_OVER : PLAY;
        end else begin
          w_next_state = DYING;
        end
      end
      LEVEL_DONE: w_next_state = w_timer_exp ? PLAY : LEVEL_DONE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_timer_nxt   = r_timer;
    w_lives_nxt   = r_lives;
    w_score_nxt   = r_score;
    w_level_nxt   = r_level;
    w_respawn_nxt = 1'b0;
    case (r_state)
      IDLE, GAME_OVER: begin
        if (startKey) begin
          w_lives_nxt   = LIVES_INIT_V;
          w_score_nxt   = 16'h0000;
          w_level_nxt   = 4'd1;
          w_respawn_nxt = 1'b1;
        end else begin
          w_respawn_nxt = 1'b0;
        end
      end
      PLAY: begin
        w_score_nxt = w_score_fg;
        if (barrelHit) begin
          // A bonus life earned on the same clock offsets the lost one.
          w_timer_nxt = DIE_V;
          w_lives_nxt = (w_bonus || r_lives == 3'd0) ? r_lives : r_lives - 3'd1;
        end else begin
          w_lives_nxt = (w_bonus && r_lives != LIVES_MAX) ? r_lives + 3'd1 : r_lives;
          w_timer_nxt = goalHit ? WIN_V : r_timer;
        end
      end
      DYING: begin
        if (w_timer_exp) begin
          w_timer_nxt   = {TIMER_W{1'b0}};
          w_respawn_nxt = (r_lives != 3'd0);
        end else if (startOfFrame) begin
          w_timer_nxt = r_timer - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      LEVEL_DONE: begin
        if (w_timer_exp) begin
          w_timer_nxt   = {TIMER_W{1'b0}};
          w_level_nxt   = (r_level < MAX_LEVEL_V) ? r_level + 4'd1 : MAX_LEVEL_V;
          w_respawn_nxt = 1'b1;
        end else if (startOfFrame) begin
          w_timer_nxt = r_timer - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      default: begin
        w_timer_nxt = {TIMER_W{1'b0}};
      end
    endcase
  end

  // Game registers; freeze tracks the state being entered so it aligns with gameState.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_timer   <= {TIMER_W{1'b0}};
      r_lives   <= LIVES_INIT_V;
      r_score   <= 16'h0000;
      r_level   <= 4'd1;
      r_respawn <= 1'b0;
      r_freeze  <= 1'b1;
    end else begin
      r_timer   <= w_timer_nxt;
      r_lives   <= w_lives_nxt;
      r_score   <= w_score_nxt;
      r_level   <= w_level_nxt;
      r_respawn <= w_respawn_nxt;
      r_freeze  <= (w_next_state != PLAY);
    end
  end

  assign gameState    = r_state;
  assign freeze       = r_freeze;
  assign respawnPulse = r_respawn;
  assign lives        = r_lives;
  assign score        = r_score;
  assign level        = r_level;

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench for game_state_controller: directed scenarios then random
// pulses, compared every clock against a decimal-arithmetic game model.
module tb_game_state_controller;
  import game_pkg::*;

  localparam int LI = 3, DIE = 60, WIN = 90, MAXL = 9;
  localparam logic [15:0] FRUIT_BCD = 16'h0010;
  localparam logic [15:0] GOAL_BCD  = 16'h0100;
`ifdef GAME_BONUS_LIFE_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN, sof, sk, fh, bh, gh;
  logic s_start, s_fruit;
  logic tie0 = 1'b0;
  game_state_t gameState, s_state;
  logic freeze, respawnPulse, s_freeze, s_resp;
  logic [2:0] lives, s_lives;
  logic [15:0] score, s_score;
  logic [3:0] level, s_level;

  int n_tests = 0, n_fail = 0;
  int m_state, m_lives, m_score, m_level, m_timer, m_resp;

  always #5 clk = ~clk;

  game_state_controller u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(sk),
    .fruitHit(fh), .barrelHit(bh), .goalHit(gh),
    .gameState(gameState), .freeze(freeze), .respawnPulse(respawnPulse),
    .lives(lives), .score(score), .level(level)
  );

  game_state_controller #(.FRUIT_POINTS(16'h9990)) u_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(tie0), .startKey(s_start),
    .fruitHit(s_fruit), .barrelHit(tie0), .goalHit(tie0),
    .gameState(s_state), .freeze(s_freeze), .respawnPulse(s_resp),
    .lives(s_lives), .score(s_score), .level(s_level)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = LI; m_score = 0; m_level = 1; m_timer = 0; m_resp = 0;
  endtask

  task automatic model_step(input logic f_sof, input logic f_sk, input logic f_fh,
                            input logic f_bh, input logic f_gh);
    int ns;
    bit bonus;
    m_resp = 0;
    case (m_state)
      0, 4: if (f_sk) begin
        m_state = 1; m_lives = LI; m_score = 0; m_level = 1; m_resp = 1;
      end
      1: begin
        ns = m_score + (f_fh ? bcd2int(FRUIT_BCD) : 0) + ((f_gh && !f_bh) ? bcd2int(GOAL_BCD) : 0);
        if (ns > 9999) ns = 9999;
        bonus = BONUS && (ns / 1000 > m_score / 1000);
        m_score = ns;
        if (f_bh) begin
          m_state = 2; m_timer = DIE;
          if (!bonus) m_lives = m_lives - 1;
        end else begin
          if (bonus && m_lives < 7) m_lives = m_lives + 1;
          if (f_gh) begin m_state = 3; m_timer = WIN; end
        end
      end
      2, 3: if (f_sof) begin
        if (m_timer == 1) begin
          m_timer = 0;
          if (m_state == 2 && m_lives == 0) m_state = 4;
          else begin
            if (m_state == 3) m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
            m_state = 1; m_resp = 1;
          end
        end else m_timer = m_timer - 1;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check_eq("state", 16'(gameState), 16'(m_state));
    check_eq("freeze", 16'(freeze), (m_state != 1) ? 16'd1 : 16'd0);
    check_eq("respawn", 16'(respawnPulse), 16'(m_resp));
    check_eq("lives", 16'(lives), 16'(m_lives));
    check_eq("score", score, int2bcd(m_score));
    check_eq("level", 16'(level), 16'(m_level));
  endtask

  task automatic step(input logic a_sof, input logic a_sk, input logic a_fh,
                      input logic a_bh, input logic a_gh);
    @(negedge clk);
    sof = a_sof; sk = a_sk; fh = a_fh; bh = a_bh; gh = a_gh;
    @(posedge clk);
    #1;
    model_step(a_sof, a_sk, a_fh, a_bh, a_gh);
    check_all();
    sof = 1'b0; sk = 1'b0; fh = 1'b0; bh = 1'b0; gh = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; sk = 1'b0; fh = 1'b0; bh = 1'b0; gh = 1'b0;
    s_start = 1'b0; s_fruit = 1'b0;
    #12;
    check_eq("rst_state", 16'(gameState), 16'd0);
    check_eq("rst_freeze", 16'(freeze), 16'd1);
    check_eq("rst_resp", 16'(respawnPulse), 16'd0);
    check_eq("rst_lives", 16'(lives), 16'd3);
    check_eq("rst_score", score, 16'h0000);
    check_eq("rst_level", 16'(level), 16'd1);
    model_reset();
    @(negedge clk) resetN = 1'b1;

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_resp", 16'(respawnPulse), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("three_fruit", score, 16'h0030);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("goal_score", score, 16'h0130);
    run_frames(89);
    check_eq("win_hold", 16'(gameState), 16'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("win_level", 16'(level), 16'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("combo_lives", 16'(lives), 16'd2);
    check_eq("combo_score", score, 16'h0140);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(59);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_frames(60);
    end
    check_eq("over_state", 16'(gameState), 16'd4);
    check_eq("over_lives", 16'(lives), 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("restart_lives", 16'(lives), 16'd3);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    #1;
    check_eq("midrst_state", 16'(gameState), 16'd0);
    check_eq("midrst_lives", 16'(lives), 16'd3);
    check_eq("midrst_freeze", 16'(freeze), 16'd1);
    check_eq("midrst_resp", 16'(respawnPulse), 16'd0);
    model_reset();
    @(negedge clk) resetN = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
    end

    @(negedge clk) s_start = 1'b1;
    @(negedge clk) begin s_start = 1'b0; s_fruit = 1'b1; end
    check_eq("sat_start", 16'(s_state), 16'd1);
    @(negedge clk);
    check_eq("sat_first", s_score, 16'h9990);
    check_eq("sat_bonus", 16'(s_lives), BONUS ? 16'd4 : 16'd3);
    @(negedge clk) s_fruit = 1'b0;
    check_eq("sat_score", s_score, 16'h9999);
    check_eq("sat_lives", 16'(s_lives), BONUS ? 16'd4 : 16'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
